// File: rtl/dff_seq_detector_if.sv
// Bus between the flip-flop stage checker and its driver.
// Carries the sample controls in and the detector status out.
interface dff_seq_detector_if #(
    parameter int HIST_W = 8,
    parameter int CNT_W  = 8
);
    logic              EN;
    logic              D;
    logic              CLR;
    logic [HIST_W-1:0] HIST;
    logic              MATCH;
    logic [CNT_W-1:0]  COUNT;
    logic              OVF;
    logic              ARMED;

    modport master (
        output EN,
        output D,
        output CLR,
        input  HIST,
        input  MATCH,
        input  COUNT,
        input  OVF,
        input  ARMED
    );

    modport slave (
        input  EN,
        input  D,
        input  CLR,
        output HIST,
        output MATCH,
        output COUNT,
        output OVF,
        output ARMED
    );
endinterface

// File: rtl/dff_seq_detector.sv
// Serial pattern detector on the flip-flop stage output Y.
// Overlapping matches, saturating counter, sticky overflow.
module dff_seq_detector #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter int                 HIST_W  = 8,
    parameter int                 CNT_W   = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    dff_seq_detector_if.slave   bus
);

    localparam int FW = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0]    FULL = FW'(PAT_LEN);
    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic [CNT_W-1:0] CONE = CNT_W'(1);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [HIST_W-1:0] hist_q;
    logic [HIST_W-1:0] hist_d;
    logic [FW-1:0]     fill_q;
    logic [FW-1:0]     fill_d;
    logic              match_q;
    logic              match_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              ovf_q;
    logic              ovf_d;
    logic [PAT_LEN-1:0] win;

    // State register: reset wins over every other input
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= FILL;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next state: shift, fill guard, match and counter update
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = 1'b0;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        win     = {hist_q[PAT_LEN-2:0], bus.D};

        if (bus.EN) begin
            hist_d = {hist_q[HIST_W-2:0], bus.D};
            if (fill_q != FULL) begin
                fill_d = fill_q + FW'(1);
            end
            // Zero-filled history after reset must never match
            match_d = (win == PATTERN) && (fill_d == FULL);
            if (state_q == FILL && fill_d == FULL) begin
                state_d = RUN;
            end
        end

        if (bus.CLR) begin
            cnt_d = match_d ? CONE : '0;
            ovf_d = 1'b0;
        end else if (match_d) begin
            if (cnt_q == CMAX) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CONE;
            end
        end
    end

    assign bus.HIST  = hist_q;
    assign bus.MATCH = match_q;
    assign bus.COUNT = cnt_q;
    assign bus.OVF   = ovf_q;
    assign bus.ARMED = (state_q == RUN);

endmodule

// File: tb/tb_dff_seq_detector.sv
// Directed bench for dff_seq_detector.
// Three instances: default, all-zero pattern, 2-bit counter.
module tb_dff_seq_detector;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic en = 1'b0;
    logic d = 1'b0;
    logic clr = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    dff_seq_detector_if #(.HIST_W(8), .CNT_W(8)) ifa ();
    dff_seq_detector_if #(.HIST_W(8), .CNT_W(8)) ifz ();
    dff_seq_detector_if #(.HIST_W(8), .CNT_W(2)) ifs ();

    assign ifa.EN = en;
    assign ifa.D = d;
    assign ifa.CLR = clr;
    assign ifz.EN = en;
    assign ifz.D = d;
    assign ifz.CLR = clr;
    assign ifs.EN = en;
    assign ifs.D = d;
    assign ifs.CLR = clr;

    dff_seq_detector #(
        .PAT_LEN(4), .PATTERN(4'b1011),
        .HIST_W(8), .CNT_W(8)
    ) u_a (.CLK(clk), .RST_N(rst_n), .bus(ifa));

    dff_seq_detector #(
        .PAT_LEN(4), .PATTERN(4'b0000),
        .HIST_W(8), .CNT_W(8)
    ) u_z (.CLK(clk), .RST_N(rst_n), .bus(ifz));

    dff_seq_detector #(
        .PAT_LEN(4), .PATTERN(4'b1011),
        .HIST_W(8), .CNT_W(2)
    ) u_s (.CLK(clk), .RST_N(rst_n), .bus(ifs));

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic e, input logic dv, input logic c);
        @(negedge clk);
        en = e;
        d = dv;
        clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b1;
        d = 1'b1;
        clr = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b0;
    endtask

    initial begin
        logic [6:0] s1;
        logic [6:0] m1;
        logic [3:0] p;
        s1 = 7'b1011011;
        m1 = 7'b0001001;
        p = 4'b1011;

        // Reset state
        do_reset();
        chk("rst_hist", 32'(ifa.HIST), 32'h0);
        chk("rst_match", 32'(ifa.MATCH), 32'h0);
        chk("rst_count", 32'(ifa.COUNT), 32'h0);
        chk("rst_ovf", 32'(ifa.OVF), 32'h0);
        chk("rst_armed", 32'(ifa.ARMED), 32'h0);

        // Overlap: 1,0,1,1,0,1,1
        for (int k = 0; k < 7; k++) begin
            step(1'b1, s1[6-k], 1'b0);
            chk($sformatf("ovl_match%0d", k + 1),
                32'(ifa.MATCH), 32'(m1[6-k]));
            chk($sformatf("ovl_armed%0d", k + 1),
                32'(ifa.ARMED), (k >= 3) ? 32'h1 : 32'h0);
        end
        chk("ovl_count", 32'(ifa.COUNT), 32'd2);
        chk("ovl_hist", 32'(ifa.HIST), 32'h5B);

        // Fill guard with all-zero pattern
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 1'b0);
            chk($sformatf("fill_match%0d", k + 1),
                32'(ifz.MATCH), (k == 3) ? 32'h1 : 32'h0);
        end
        chk("fill_count", 32'(ifz.COUNT), 32'd1);

        // EN gating
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 1'b0);
            chk($sformatf("gate_hist%0d", k), 32'(ifa.HIST), 32'h2);
            chk($sformatf("gate_match%0d", k), 32'(ifa.MATCH), 32'h0);
        end
        step(1'b1, 1'b1, 1'b0);
        chk("gate_m3", 32'(ifa.MATCH), 32'h0);
        step(1'b1, 1'b1, 1'b0);
        chk("gate_m4", 32'(ifa.MATCH), 32'h1);
        chk("gate_hist", 32'(ifa.HIST), 32'hB);
        chk("gate_count", 32'(ifa.COUNT), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        chk("gate_pulse", 32'(ifa.MATCH), 32'h0);

        // Reset mid-operation
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        do_reset();
        chk("mid_hist", 32'(ifa.HIST), 32'h0);
        step(1'b1, 1'b1, 1'b0);
        chk("mid_lone", 32'(ifa.MATCH), 32'h0);
        chk("mid_arm1", 32'(ifa.ARMED), 32'h0);
        step(1'b1, 1'b1, 1'b0);
        chk("mid_arm2", 32'(ifa.ARMED), 32'h0);
        step(1'b1, 1'b0, 1'b0);
        chk("mid_arm3", 32'(ifa.ARMED), 32'h0);
        step(1'b1, 1'b1, 1'b0);
        chk("mid_arm4", 32'(ifa.ARMED), 32'h1);
        chk("mid_m4", 32'(ifa.MATCH), 32'h0);
        step(1'b1, 1'b1, 1'b0);
        chk("mid_m5", 32'(ifa.MATCH), 32'h1);
        chk("mid_count", 32'(ifa.COUNT), 32'd1);

        // Saturation on the 2-bit counter
        do_reset();
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                step(1'b1, p[3-k], 1'b0);
            end
            chk($sformatf("sat_match%0d", r + 1), 32'(ifs.MATCH), 32'h1);
            chk($sformatf("sat_count%0d", r + 1),
                32'(ifs.COUNT), (r >= 2) ? 32'd3 : 32'(r + 1));
            chk($sformatf("sat_ovf%0d", r + 1),
                32'(ifs.OVF), (r == 3) ? 32'h1 : 32'h0);
        end
        step(1'b1, 1'b1, 1'b0);
        chk("sat_sticky", 32'(ifs.OVF), 32'h1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("clr_match", 32'(ifs.MATCH), 32'h1);
        chk("clr_count", 32'(ifs.COUNT), 32'd1);
        chk("clr_ovf", 32'(ifs.OVF), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
